// File: rtl/bcd_pkg.sv
// Shared types and defaults for the binary-to-BCD converter and the
// seven-segment digit decoder downstream of it.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam int BIN_W_DEFAULT  = 9;
    localparam int DIGITS_DEFAULT = 4;

    // True when digits decimal places can hold the largest bin_w-bit value.
    function automatic bit bcd_range_ok(input int bin_w, input int digits);
        longint pow10;
        pow10 = 1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 10;
        end
        return (pow10 - 1) >= ((longint'(1) << bin_w) - 1);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: values of 5 and above get +3 so the
// following left shift carries into the next decimal digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);

    assign q = (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock,
// result held on o_bcd and announced with a single-cycle o_done pulse.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int P_BIN_W  = BIN_W_DEFAULT,
    parameter int P_DIGITS = DIGITS_DEFAULT
) (
    input  logic                    i_clock_50mhz,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [P_BIN_W-1:0]      i_bin,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [P_DIGITS*4-1:0]   o_bcd
);

    localparam int SCR_W = P_DIGITS * 4;
    localparam int CNT_W = $clog2(P_BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(P_BIN_W - 1);

    generate
        if (!bcd_range_ok(P_BIN_W, P_DIGITS)) begin : g_range_err
            $error("bin_to_bcd_seq: P_DIGITS too small for P_BIN_W");
        end
    endgenerate

    state_t             state_reg,   state_next;
    logic [P_BIN_W-1:0] bin_reg,     bin_next;
    logic [SCR_W-1:0]   scratch_reg, scratch_next;
    logic [CNT_W-1:0]   cnt_reg,     cnt_next;
    logic [SCR_W-1:0]   bcd_reg,     bcd_next;
    logic               done_reg,    done_next;

    logic [SCR_W-1:0]   scratch_adj;
    logic [SCR_W-1:0]   scratch_shift;

    genvar gi;
    generate
        for (gi = 0; gi < P_DIGITS; gi++) begin : g_digit
            bcd_add3 u_add3 (
                .d (scratch_reg[gi*4 +: 4]),
                .q (scratch_adj[gi*4 +: 4])
            );
        end
    endgenerate

    // The binary MSB feeds scratch bit 0 as the combined register shifts left.
    assign scratch_shift = {scratch_adj[SCR_W-2:0], bin_reg[P_BIN_W-1]};

    always_comb begin
        state_next   = state_reg;
        bin_next     = bin_reg;
        scratch_next = scratch_reg;
        cnt_next     = cnt_reg;
        bcd_next     = bcd_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    state_next   = SHIFT;
                    bin_next     = i_bin;
                    scratch_next = '0;
                    cnt_next     = '0;
                end
            end
            SHIFT: begin
                scratch_next = scratch_shift;
                bin_next     = bin_reg << 1;
                cnt_next     = cnt_reg + 1'b1;
                if (cnt_reg == LAST_STEP) begin
                    state_next = IDLE;
                    bcd_next   = scratch_shift;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock_50mhz or negedge i_reset) begin
        if (!i_reset) begin
            state_reg   <= IDLE;
            bin_reg     <= '0;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            bcd_reg     <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bin_reg     <= bin_next;
            scratch_reg <= scratch_next;
            cnt_reg     <= cnt_next;
            bcd_reg     <= bcd_next;
            done_reg    <= done_next;
        end
    end

    assign o_busy = (state_reg == SHIFT);
    assign o_done = done_reg;
    assign o_bcd  = bcd_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: fixed vectors, an exhaustive
// back-to-back sweep, ignored start, async abort and input scrambling.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [8:0]  bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;

    int checks;
    int errors;

    bin_to_bcd_seq #(.P_BIN_W(9), .P_DIGITS(4)) dut (
        .i_clock_50mhz (clk),
        .i_reset       (rst_n),
        .i_start       (start),
        .i_bin         (bin),
        .o_busy        (busy),
        .o_done        (done),
        .o_bcd         (bcd)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [15:0] ref_bcd(input int v);
        return 16'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Issue a start at a negedge; returns at the negedge after acceptance.
    task automatic do_start(input logic [8:0] v);
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for o_done, counting busy cycles seen on the way.
    task automatic wait_done(input bit scramble, output bit seen, output int busy_n);
        seen   = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_n++;
            if (scramble) bin = 9'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic run(input logic [8:0] v, input logic [15:0] exp, input string tag);
        bit seen;
        int busy_n;
        do_start(v);
        wait_done(1'b0, seen, busy_n);
        chk({tag, "_done"}, int'(seen), 1);
        chk({tag, "_bcd"}, int'(bcd), int'(exp));
        chk({tag, "_busy_cycles"}, busy_n, 9);
        $display("conv %0d -> bcd 0x%04h busy_cycles=%0d", v, bcd, busy_n);
        @(negedge clk);
        chk({tag, "_done_pulse"}, int'(done), 0);
    endtask

    initial begin
        bit seen;
        int busy_n;
        int cyc;
        int extra;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin    = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_bcd", int'(bcd), 0);
        $display("reset: busy=%0b done=%0b bcd=0x%04h", busy, done, bcd);
        rst_n = 1'b1;
        @(negedge clk);

        run(9'd0,   16'h0000, "v0");
        run(9'd511, 16'h0511, "v511");
        run(9'd255, 16'h0255, "v255");
        run(9'd100, 16'h0100, "v100");
        run(9'd9,   16'h0009, "v9");

        // Exhaustive sweep with each new start issued on the done cycle.
        @(negedge clk);
        bin   = 9'd0;
        start = 1'b1;
        for (int v = 0; v < 512; v++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                start = 1'b0;
                cyc++;
            end while (!done && cyc < 30);
            chk("sweep_period", cyc, 10);
            chk("sweep_bcd", int'(bcd), int'(ref_bcd(v)));
            if (v % 64 == 0)
                $display("sweep %0d -> bcd 0x%04h period=%0d", v, bcd, cyc);
            if (v < 511) begin
                bin   = 9'(v + 1);
                start = 1'b1;
            end
        end
        @(negedge clk);

        // Start while busy must be ignored.
        do_start(9'd123);
        repeat (3) @(negedge clk);
        bin   = 9'd456;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, seen, busy_n);
        chk("ign_done", int'(seen), 1);
        chk("ign_bcd", int'(bcd), 16'h0123);
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("ign_extra_done", extra, 0);
        chk("ign_idle", int'(busy), 0);
        $display("ignored start: bcd 0x%04h extra_dones=%0d", bcd, extra);

        // Asynchronous abort mid-conversion.
        run(9'd77, 16'h0077, "v77");
        do_start(9'd300);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_bcd", int'(bcd), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        $display("abort: busy=%0b done=%0b bcd=0x%04h", busy, done, bcd);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk("abort_no_done", extra, 0);
        run(9'd42, 16'h0042, "v42");

        // Input scrambled throughout the conversion.
        do_start(9'd321);
        wait_done(1'b1, seen, busy_n);
        chk("scr_done", int'(seen), 1);
        chk("scr_bcd", int'(bcd), 16'h0321);
        $display("scramble: bcd 0x%04h", bcd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
